// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with sub-word RMW stores
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t      state;

    // Only the parts of the request still needed after acceptance are kept:
    // width code, byte offset within the word, and the sub-word store data.
    logic [2:0]  op_funct3;
    logic [1:0]  op_off;
    logic [15:0] op_wdata;

    logic        req_legal;
    logic        req_misaligned;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_value;
    logic [31:0] merge_word;

    // Classify the incoming request: legal width code and natural alignment.
    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        if (req_write) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                default:                                req_legal = 1'b0;
            endcase
        end
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = 1'b0;
        endcase
    end

    // Select and extend the addressed byte/halfword of the returned word.
    always_comb begin
        case (op_off)
            2'd0:    load_byte = mem_read_data[7:0];
            2'd1:    load_byte = mem_read_data[15:8];
            2'd2:    load_byte = mem_read_data[23:16];
            default: load_byte = mem_read_data[31:24];
        endcase
        load_half = op_off[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (op_funct3)
            3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_value = {{16{load_half[15]}}, load_half};
            3'b100:  load_value = {24'h000000, load_byte};
            3'b101:  load_value = {16'h0000, load_half};
            default: load_value = mem_read_data;
        endcase
    end

    // Merge the sub-word store data into the word read back during RMW_RD.
    always_comb begin
        merge_word = mem_read_data;
        if (op_funct3[1:0] == 2'b00) begin
            case (op_off)
                2'd0:    merge_word[7:0]   = op_wdata[7:0];
                2'd1:    merge_word[15:8]  = op_wdata[7:0];
                2'd2:    merge_word[23:16] = op_wdata[7:0];
                default: merge_word[31:24] = op_wdata[7:0];
            endcase
        end else if (op_off[1]) begin
            merge_word[31:16] = op_wdata;
        end else begin
            merge_word[15:0] = op_wdata;
        end
    end

    // Control FSM; every memory-facing and response output is a flop so the
    // combinational memory only ever sees clean, state-aligned values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= 32'h0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
            op_funct3      <= 3'b000;
            op_off         <= 2'b00;
            op_wdata       <= 16'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_funct3   <= req_funct3;
                        op_off      <= req_addr[1:0];
                        op_wdata    <= req_wdata[15:0];
                        mem_address <= {req_addr[31:2], 2'b00};
                        req_ready   <= 1'b0;
                        if (!req_legal || req_misaligned) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (!req_write) begin
                            state    <= S_LOAD;
                            mem_read <= 1'b1;
                        end else if (req_funct3 == 3'b010) begin
                            state          <= S_STORE;
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            state    <= S_RMW_RD;
                            mem_read <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    mem_read   <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= load_value;
                    state      <= S_RESP;
                end
                S_STORE: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'h0;
                    state      <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_read       <= 1'b0;
                    mem_write      <= 1'b1;
                    mem_write_data <= merge_word;
                    state          <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    mem_write  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'h0;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    // Data memory stand-in (64 words) and the reference model's copy.
    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    // Results observed during the last request.
    int          r_resp_cyc;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [7:0]  r_rd_mask;
    logic [7:0]  r_wr_mask;
    logic [31:0] r_wdata;
    logic        r_both;
    logic        r_addr_bad;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (mem_write)
            mem[mem_address[7:2]] <= mem_write_data;
        else if (pre_we)
            mem[pre_idx] <= pre_data;
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference rules: legality and natural alignment by access size.
    function automatic logic ref_is_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        int   sz;
        if (w) legal = (f3 <= 3'd2);
        else   legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 1'b1;
        sz = 1 << f3[1:0];
        return (a % sz) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] word, b, h;
        word = ref_mem[a[7:2]];
        b = (word >> (8 * (a % 4))) & 32'hFF;
        h = (word >> (8 * (a % 4))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] word, mask;
        int sh;
        if (f3 == 3'd2) return wd;
        word = ref_mem[a[7:2]];
        sh   = 8 * (a % 4);
        mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    // Issue one request, watch five cycles after acceptance, compare with model.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic        e;
        int          exp_resp;
        logic [7:0]  exp_rd, exp_wr;
        logic [31:0] exp_rdata, exp_wdata;
        int          waitc;
        waitc = 0;
        while (!req_ready && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        check32("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        r_resp_cyc = 0; r_rd_mask = 8'h0; r_wr_mask = 8'h0; r_wdata = 32'h0;
        r_rdata = 32'h0; r_err = 1'b0; r_both = 1'b0; r_addr_bad = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (mem_read) r_rd_mask[k] = 1'b1;
            if (mem_write) begin
                r_wr_mask[k] = 1'b1;
                r_wdata = mem_write_data;
            end
            if (mem_read && mem_write) r_both = 1'b1;
            if ((mem_read || mem_write) && mem_address !== {a[31:2], 2'b00}) r_addr_bad = 1'b1;
            if (resp_valid) begin
                r_resp_cyc = (r_resp_cyc != 0) ? 99 : k;
                r_rdata = resp_rdata;
                r_err = resp_error;
            end
            if (req_ready) begin
                req_valid = 1'b0;
            end else begin
                req_valid  = 1'($urandom % 2);
                req_write  = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr   = $urandom;
                req_wdata  = $urandom;
            end
        end
        e = ref_is_err(w, f3, a);
        exp_rd = 8'h0; exp_wr = 8'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;
        if (e) begin
            exp_resp = 1;
        end else if (!w) begin
            exp_resp = 2; exp_rd = 8'b0000_0010; exp_rdata = ref_load(f3, a);
        end else if (f3 == 3'd2) begin
            exp_resp = 2; exp_wr = 8'b0000_0010; exp_wdata = ref_store(f3, a, wd);
        end else begin
            exp_resp = 3; exp_rd = 8'b0000_0010; exp_wr = 8'b0000_0100; exp_wdata = ref_store(f3, a, wd);
        end
        check32("resp_cycle", 32'(r_resp_cyc), 32'(exp_resp));
        check32("resp_error", {31'b0, r_err}, {31'b0, e});
        check32("resp_rdata", r_rdata, exp_rdata);
        check32("mem_read_cycles", {24'b0, r_rd_mask}, {24'b0, exp_rd});
        check32("mem_write_cycles", {24'b0, r_wr_mask}, {24'b0, exp_wr});
        check32("mem_write_data", r_wdata, exp_wdata);
        check32("rd_wr_overlap", {31'b0, r_both}, 32'd0);
        check32("mem_address", {31'b0, r_addr_bad}, 32'd0);
        check32("ready_after_req", {31'b0, req_ready}, 32'd1);
        if (w && !e) begin
            ref_mem[a[7:2]] = exp_wdata;
            check32("mem_word_after_store", mem[a[7:2]], ref_mem[a[7:2]]);
        end
    endtask

    initial begin
        logic        seen_bad;
        int          gap;
        logic [31:0] w_lw;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        pre_we = 1'b0; pre_idx = 6'd0; pre_data = 32'h0;

        // Preload memory while in reset.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_idx = 6'(i);
            pre_data = (i == 16) ? 32'h8899AABB : $urandom;
            ref_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;

        check32("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check32("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check32("rst_resp_error", {31'b0, resp_error}, 32'd0);
        check32("rst_resp_rdata", resp_rdata, 32'h0);
        check32("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check32("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check32("rst_mem_address", mem_address, 32'h0);
        check32("rst_mem_write_data", mem_write_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed accesses around word 0x40.
        do_req(1'b0, 3'b000, 32'h41, 32'h0);
        check32("lb_0x41", r_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 3'b101, 32'h42, 32'h0);
        check32("lhu_0x42", r_rdata, 32'h00008899);
        do_req(1'b0, 3'b001, 32'h40, 32'h0);
        check32("lh_0x40", r_rdata, 32'hFFFFAABB);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        check32("lw_0x40", r_rdata, 32'h8899AABB);
        do_req(1'b1, 3'b000, 32'h43, 32'h12345677);
        check32("sb_0x43_wdata", r_wdata, 32'h7799AABB);
        do_req(1'b0, 3'b010, 32'h40, 32'h0);
        check32("lw_after_sb", r_rdata, 32'h7799AABB);
        do_req(1'b0, 3'b010, 32'h46, 32'h0);
        check32("lw_misaligned_err", {31'b0, r_err}, 32'd1);
        do_req(1'b1, 3'b001, 32'h41, 32'hDEADBEEF);
        check32("sh_misaligned_err", {31'b0, r_err}, 32'd1);
        do_req(1'b0, 3'b011, 32'h40, 32'h0);
        check32("load_f3_011_err", {31'b0, r_err}, 32'd1);

        // Reset taken during RMW_RD of an SH must drop the request.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check32("rmw_rd_mem_read", {31'b0, mem_read}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check32("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        check32("midrst_mem_write", {31'b0, mem_write}, 32'd0);
        rst_n = 1'b1;
        seen_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (mem_write || resp_valid) seen_bad = 1'b1;
            @(negedge clk);
        end
        check32("midrst_no_write_no_resp", {31'b0, seen_bad}, 32'd0);
        check32("midrst_mem_unchanged", mem[16], ref_mem[16]);

        // Back-to-back with req_valid held high: SW then LW at 0x80.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h80; req_wdata = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        req_write = 1'b0; req_wdata = 32'h0;
        gap = 1;
        while (!req_ready && gap < 8) begin
            @(negedge clk);
            gap++;
        end
        check32("b2b_accept_gap", 32'(gap), 32'd3);
        @(posedge clk);
        w_lw = 32'h0;
        seen_bad = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid && k == 2) begin
                seen_bad = 1'b0;
                w_lw = resp_rdata;
            end
        end
        ref_mem[32] = 32'h11111111;
        check32("b2b_lw_resp_at_2", {31'b0, seen_bad}, 32'd0);
        check32("b2b_lw_data", w_lw, 32'h11111111);
        check32("b2b_mem_word", mem[32], 32'h11111111);

        // Randomized requests checked against the reference model.
        for (int n = 0; n < 200; n++) begin
            do_req(1'($urandom), 3'($urandom), 32'($urandom_range(0, 255)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
